serial_line_arbiter: RTL and testbench

SERIAL_LINE_ARBITER -- requirements
Module: serial_line_arbiter

---
 rtl/serial_line_arbiter_if.sv | 33 +++
 rtl/serial_line_arbiter.sv | 148 ++++++++++++++
 tb/tb_serial_line_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_line_arbiter_if.sv
// Shared serial line bundle: per-requester request/data in,
// grant, line enable, muxed data and end-of-grant pulses out.
interface serial_line_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] ser_in;
  logic [N_REQ-1:0] gnt;
  logic             line_en;
  logic             ser_out;
  logic [N_REQ-1:0] done;
  logic             timeout;

  modport master (
    output req,
    output ser_in,
    input  gnt,
    input  line_en,
    input  ser_out,
    input  done,
    input  timeout
  );

  modport slave (
    input  req,
    input  ser_in,
    output gnt,
    output line_en,
    output ser_out,
    output done,
    output timeout
  );
endinterface

// File: rtl/serial_line_arbiter.sv
// Round-robin owner of one idle-high serial line with per-grant
// length limit and a guard gap between consecutive grants.
module serial_line_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_BITS = 32,
  parameter int GAP      = 1
) (
  input logic                  clk,
  input logic                  rst,
  serial_line_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BITS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GUARD
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_n;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    owner_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [3:0]       gcnt;
  logic [3:0]       gcnt_n;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] gnt_n;
  logic [N_REQ-1:0] done_q;
  logic [N_REQ-1:0] done_n;
  logic             line_q;
  logic             line_n;
  logic             to_q;
  logic             to_n;

  logic             found;
  logic [PW-1:0]    pick;
  logic [PW:0]      sum;
  logic [PW-1:0]    cand;
  logic             own_req;
  logic             expired;

  // First requester at or above ptr, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ))
        sum = sum - (PW+1)'(N_REQ);
      cand = sum[PW-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign own_req = bus.req[owner];
  assign expired = (cnt == CW'(MAX_BITS - 1));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    gnt_n   = gnt_q;
    line_n  = line_q;
    done_n  = '0;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          owner_n = pick;
          gnt_n   = N_REQ'(1) << pick;
          line_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        // A release in the expiry cycle wins: timeout stays low
        if (!own_req || expired) begin
          state_n = GUARD;
          gnt_n   = '0;
          line_n  = 1'b0;
          done_n  = gnt_q;
          to_n    = own_req;
          gcnt_n  = '0;
          ptr_n   = (owner == PW'(N_REQ - 1)) ? '0
                                              : owner + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GUARD: begin
        if (gcnt == 4'(GAP - 1))
          state_n = IDLE;
        else
          gcnt_n = gcnt + 1'b1;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        line_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      gnt_q  <= '0;
      line_q <= 1'b0;
      done_q <= '0;
      to_q   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      owner  <= owner_n;
      cnt    <= cnt_n;
      gcnt   <= gcnt_n;
      gnt_q  <= gnt_n;
      line_q <= line_n;
      done_q <= done_n;
      to_q   <= to_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.line_en = line_q;
  assign bus.done    = done_q;
  assign bus.timeout = to_q;
  assign bus.ser_out = line_q ? bus.ser_in[owner] : 1'b1;

endmodule

// File: tb/tb_serial_line_arbiter.sv
// Directed vector bench for serial_line_arbiter: three instances
// cover release/priority, MAX_BITS expiry and a wide guard gap.
module tb_serial_line_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_line_arbiter_if #(.N_REQ(4)) ia ();
  serial_line_arbiter_if #(.N_REQ(4)) ib ();
  serial_line_arbiter_if #(.N_REQ(4)) ic ();

  serial_line_arbiter #(
    .N_REQ(4), .MAX_BITS(8), .GAP(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));

  serial_line_arbiter #(
    .N_REQ(4), .MAX_BITS(4), .GAP(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  serial_line_arbiter #(
    .N_REQ(4), .MAX_BITS(8), .GAP(3)
  ) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  typedef struct {
    logic       r;
    logic [3:0] req;
    logic [3:0] ser;
    logic [3:0] gnt;
    logic       len;
    logic       so;
    logic [3:0] done;
    logic       to;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input logic r, input logic [3:0] rq, input logic [3:0] s,
    input logic [3:0] g, input logic l, input logic so,
    input logic [3:0] d, input logic t);
    vec_t x;
    x.r = r; x.req = rq; x.ser = s; x.gnt = g;
    x.len = l; x.so = so; x.done = d; x.to = t;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ia.req = '0; ia.ser_in = '0;
    ib.req = '0; ib.ser_in = '0;
    ic.req = '0; ic.ser_in = '0;

    // reset, single requester 0 released after 5 cycles
    tv.push_back(v(1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, 0));
    tv.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, 0));
    tv.push_back(v(0, 4'b0001, 4'b1110, 4'b0001, 1, 0, 4'b0000, 0));
    tv.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0001, 0));
    tv.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0));
    // owner 2 holds the line while others toggle
    tv.push_back(v(0, 4'b0100, 4'b0100, 4'b0100, 1, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b1111, 4'b0000, 4'b0100, 1, 0, 4'b0000, 0));
    tv.push_back(v(0, 4'b0110, 4'b1011, 4'b0100, 1, 0, 4'b0000, 0));
    tv.push_back(v(0, 4'b1111, 4'b0100, 4'b0100, 1, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b1011, 4'b0100, 4'b0000, 0, 1, 4'b0100, 0));
    tv.push_back(v(0, 4'b1011, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b1011, 4'b1000, 4'b1000, 1, 1, 4'b0000, 0));
    // owner 3 drops req exactly when counter hits MAX_BITS-1
    for (int i = 0; i < 7; i++)
      tv.push_back(v(0, 4'b1000, 4'b0000, 4'b1000, 1, 0, 4'b0000, 0));
    tv.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b1000, 0));
    tv.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0));
    // owner 1 twice (ptr ends at 2), then reset mid-grant
    tv.push_back(v(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0010, 0));
    tv.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b0010, 4'b0000, 4'b0010, 1, 0, 4'b0000, 0));
    tv.push_back(v(0, 4'b0010, 4'b0010, 4'b0010, 1, 1, 4'b0000, 0));
    tv.push_back(v(1, 4'b0010, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b0110, 4'b0010, 4'b0010, 1, 1, 4'b0000, 0));
    tv.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0010, 0));
    tv.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0));

    foreach (tv[k]) begin
      rst       = tv[k].r;
      ia.req    = tv[k].req;
      ia.ser_in = tv[k].ser;
      step();
      chk($sformatf("a_gnt[%0d]", k), 32'(ia.gnt), 32'(tv[k].gnt));
      chk($sformatf("a_len[%0d]", k), 32'(ia.line_en), 32'(tv[k].len));
      chk($sformatf("a_so[%0d]", k), 32'(ia.ser_out), 32'(tv[k].so));
      chk($sformatf("a_done[%0d]", k), 32'(ia.done), 32'(tv[k].done));
      chk($sformatf("a_to[%0d]", k), 32'(ia.timeout), 32'(tv[k].to));
    end

    // all four requesting with MAX_BITS=4: forced rotation 0,1,2,3,0
    ib.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      logic [1:0] own;
      own = 2'(g % 4);
      oh  = 4'b0001 << own;
      for (int c = 0; c < 4; c++) begin
        ib.ser_in = 4'($urandom);
        step();
        chk($sformatf("b_gnt g%0d c%0d", g, c), 32'(ib.gnt), 32'(oh));
        chk("b_so", 32'(ib.ser_out), 32'(ib.ser_in[own]));
        chk("b_to_low", 32'(ib.timeout), 32'd0);
      end
      step();
      chk($sformatf("b_end_gnt g%0d", g), 32'(ib.gnt), 32'd0);
      chk($sformatf("b_done g%0d", g), 32'(ib.done), 32'(oh));
      chk($sformatf("b_to g%0d", g), 32'(ib.timeout), 32'd1);
      step();
      chk("b_guard_gnt", 32'(ib.gnt), 32'd0);
      chk("b_guard_done", 32'(ib.done), 32'd0);
      chk("b_guard_to", 32'(ib.timeout), 32'd0);
    end
    ib.req = '0;

    // GAP=3: re-request right after release waits out the guard
    ic.req = 4'b0001;
    step();
    chk("c_gnt0", 32'(ic.gnt), 32'h1);
    step();
    chk("c_gnt1", 32'(ic.gnt), 32'h1);
    ic.req = 4'b0000;
    step();
    chk("c_rel_gnt", 32'(ic.gnt), 32'h0);
    chk("c_rel_done", 32'(ic.done), 32'h1);
    chk("c_rel_to", 32'(ic.timeout), 32'h0);
    ic.req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("c_guard%0d", k), 32'(ic.gnt), 32'h0);
      chk("c_guard_len", 32'(ic.line_en), 32'h0);
    end
    step();
    chk("c_regrant", 32'(ic.gnt), 32'h1);
    chk("c_regrant_len", 32'(ic.line_en), 32'h1);
    ic.req = 4'b0000;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
